// File: rtl/fp_div_sched.sv
// fp_div_sched: shared iterative single-precision divider serving two requesters.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req{0,1}_valid/_ready    per-requester handshake (accept on valid && ready)
//   req{0,1}_in1, _in2       IEEE-754 dividend / divisor
//   res_valid/res_ready      result handshake (consume on valid && ready)
//   res_out, res_id          quotient {sign,exp,mantissa} and owning requester
//
// One operation is in flight at a time. The acceptance edge loads DIVIDE.
// DIVIDE lasts 25 cycles (one quotient bit each), NORM lasts 1 cycle, and DONE
// holds the result. Counting the acceptance edge as the first, res_valid rises
// after the 27th edge. Results are truncated, and no rounding is applied.
//
// Optional build macro FP_DIV_SPECIAL_EN: a zero-exponent divisor gives signed
// infinity, and a zero-exponent dividend gives signed zero. Both go straight to
// DONE on the acceptance edge, so the latency is 1.

module fp_div_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [31:0] req0_in1,
  input  logic [31:0] req0_in2,
  input  logic [31:0] req1_in1,
  input  logic [31:0] req1_in2,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        res_valid,
  output logic [31:0] res_out,
  output logic        res_id,
  input  logic        res_ready
);

  typedef enum logic [1:0] {StIdle, StDivide, StNorm, StDone} state_e;

  state_e      state_q, state_d;
  logic        last_grant_q;
  logic        owner_q;
  logic        sign_q;
  logic [7:0]  exp_q;
  logic [24:0] rem_q;
  logic [23:0] m2_q;
  logic [24:0] quo_q;
  logic [4:0]  cnt_q;
  logic [31:0] res_q;

  logic        grant;
  logic        accept;
  logic [31:0] op1, op2;
  logic        op_sign;
  logic        ge;
  logic [23:0] rem_diff;
  logic [24:0] rem_next;
  logic        special;
  logic [31:0] special_res;

  // Arbiter: a lone requester wins, and contention goes to whoever lost last time.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = !rst && (state_q == StIdle) && !grant;
  assign req1_ready = !rst && (state_q == StIdle) && grant;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign op1     = grant ? req1_in1 : req0_in1;
  assign op2     = grant ? req1_in2 : req0_in2;
  assign op_sign = op1[31] ^ op2[31];

`ifdef FP_DIV_SPECIAL_EN
  assign special     = (op2[30:23] == 8'd0) || (op1[30:23] == 8'd0);
  assign special_res = (op2[30:23] == 8'd0) ? {op_sign, 8'hff, 23'h0} : {op_sign, 31'h0};
`else
  assign special     = 1'b0;
  assign special_res = 32'h0;
`endif

  // Restoring step. The remainder stays below 2*m2, so the shift never drops a set bit.
  // When ge, the difference is below m2 and fits in 24 bits.
  assign ge       = rem_q >= {1'b0, m2_q};
  assign rem_diff = rem_q[23:0] - m2_q;
  assign rem_next = ge ? {rem_diff, 1'b0} : {rem_q[23:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = special ? StDone : StDivide;
      StDivide: if (cnt_q == 5'd24) state_d = StNorm;
      StNorm:   state_d = StDone;
      StDone:   if (res_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      sign_q       <= 1'b0;
      exp_q        <= 8'd0;
      rem_q        <= 25'd0;
      m2_q         <= 24'd0;
      quo_q        <= 25'd0;
      cnt_q        <= 5'd0;
      res_q        <= 32'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            last_grant_q <= grant;
            owner_q      <= grant;
            sign_q       <= op_sign;
            exp_q        <= op1[30:23] - op2[30:23] + 8'd127;
            rem_q        <= {2'b01, op1[22:0]};
            m2_q         <= {1'b1, op2[22:0]};
            quo_q        <= 25'd0;
            cnt_q        <= 5'd0;
            if (special) res_q <= special_res;
          end
        end
        StDivide: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[23:0], ge};
          cnt_q <= cnt_q + 5'd1;
        end
        StNorm: begin
          cnt_q <= 5'd0;
          if (quo_q[24]) begin
            res_q <= {sign_q, exp_q, quo_q[23:1]};
          end else begin
            res_q <= {sign_q, exp_q - 8'd1, quo_q[22:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign res_valid = !rst && (state_q == StDone);
  assign res_out   = res_q;
  assign res_id    = owner_q;

endmodule

// File: tb/tb_fp_div_sched.sv
// tb_fp_div_sched: directed and randomized checks of fp_div_sched against an
// arithmetic reference model (quotient by integer division, arbiter by last-winner).

module tb_fp_div_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_in1, req0_in2, req1_in1, req1_in2;
  logic        req0_ready, req1_ready;
  logic        res_valid;
  logic [31:0] res_out;
  logic        res_id;
  logic        res_ready;

  int   total = 0;
  int   bad   = 0;
  logic tb_last;

  fp_div_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_in1   (req0_in1),
    .req0_in2   (req0_in2),
    .req1_in1   (req1_in1),
    .req1_in2   (req1_in2),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_out    (res_out),
    .res_id     (res_id),
    .res_ready  (res_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    longint unsigned   q;
    int                e;
    logic [22:0]       mant;
    s = a[31] ^ b[31];
`ifdef FP_DIV_SPECIAL_EN
    if (b[30:23] == 8'd0) return {s, 8'hff, 23'h0};
    if (a[30:23] == 8'd0) return {s, 31'h0};
`endif
    q = (64'({1'b1, a[22:0]}) << 24) / 64'({1'b1, b[22:0]});
    e = int'({24'd0, a[30:23]}) - int'({24'd0, b[30:23]}) + 127;
    if (q >= 64'd16777216) begin
      mant = 23'(q >> 1);
    end else begin
      mant = 23'(q);
      e    = e - 1;
    end
    return {s, 8'(e), mant};
  endfunction

  function automatic int lat_model(input logic [31:0] a, input logic [31:0] b);
`ifdef FP_DIV_SPECIAL_EN
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 1;
`endif
    return 27;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after the acceptance edge, which counts as latency edge 1.
  task automatic wait_result(input logic [31:0] expv, input logic id, input int lat,
                             input int stall);
    int n = 1;
    while (!res_valid && n < 100) begin
      check("busy_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      step();
      n++;
    end
    check("latency", n, lat);
    check("res_out", res_out, expv);
    check("res_id", {31'd0, res_id}, {31'd0, id});
    if (stall > 0) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      for (int i = 0; i < stall; i++) begin
        check("stall_valid", {31'd0, res_valid}, 32'd1);
        check("stall_out", res_out, expv);
        check("stall_id", {31'd0, res_id}, {31'd0, id});
        check("stall_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        step();
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("idle_after", {31'd0, res_valid}, 32'd0);
  endtask

  task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                        input int stall);
    int n = 0;
    if (id == 0) begin
      req0_in1 = a; req0_in2 = b; req0_valid = 1'b1;
    end else begin
      req1_in1 = a; req1_in2 = b; req1_valid = 1'b1;
    end
    #1;
    while (!(id == 0 ? req0_ready : req1_ready) && n < 200) begin
      step();
      n++;
    end
    check("ready_wait", {31'd0, n < 200}, 32'd1);
    check("other_ready", {31'd0, id == 0 ? req1_ready : req0_ready}, 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tb_last = id[0];
    wait_result(model(a, b), id[0], lat_model(a, b), stall);
  endtask

  task automatic contend(input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1);
    logic first;
    first = ~tb_last;
    req0_in1 = a0; req0_in2 = b0; req1_in1 = a1; req1_in2 = b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("arb_ready0", {31'd0, req0_ready}, {31'd0, !first});
    check("arb_ready1", {31'd0, req1_ready}, {31'd0, first});
    @(posedge clk);
    #1;
    if (first) req1_valid = 1'b0;
    else       req0_valid = 1'b0;
    tb_last = first;
    wait_result(first ? model(a1, b1) : model(a0, b0), first,
                first ? lat_model(a1, b1) : lat_model(a0, b0), 0);
    check("second_ready", {31'd0, first ? req0_ready : req1_ready}, 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tb_last = ~first;
    wait_result(first ? model(a0, b0) : model(a1, b1), ~first,
                first ? lat_model(a0, b0) : lat_model(a1, b1), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic        seen;
    int          id;
    logic [31:0] a, b;
    rst        = 1'b1;
    res_ready  = 1'b0;
    tb_last    = 1'b1;
    req0_in1   = 32'h40c00000;
    req0_in2   = 32'h40000000;
    req1_in1   = 32'h3f800000;
    req1_in2   = 32'h40400000;
    req0_valid = 1'b1;
    req1_valid = 1'b1;

    // Reset state, with both requesters asking.
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      check("rst_valid", {31'd0, res_valid}, 32'd0);
      check("rst_out", res_out, 32'd0);
      check("rst_id", {31'd0, res_id}, 32'd0);
    end
    rst = 1'b0;

    // Contention right after reset: 6/2 on req0 first, then 1/3 on req1.
    contend(32'h40c00000, 32'h40000000, 32'h3f800000, 32'h40400000);
    check("ref_6div2", model(32'h40c00000, 32'h40000000), 32'h40400000);
    check("ref_1div3", model(32'h3f800000, 32'h40400000), 32'h3eaaaaaa);

    // Back-pressure held in DONE.
    run_op(1, 32'h3f800000, 32'h40400000, 10);

    // After a lone req0, contention must now favour req1.
    run_op(0, 32'h40c00000, 32'h40000000, 0);
    contend(32'h41200000, 32'h40a00000, 32'hc0e00000, 32'h3f000000);

    // Zero-exponent operands (special path when the macro is defined).
    run_op(1, 32'hbf800000, 32'h00000000, 0);
    run_op(0, 32'h00400000, 32'h3f800000, 0);

    // Reset in the 10th DIVIDE cycle abandons the operation.
    req0_in1 = 32'h40c00000;
    req0_in2 = 32'h40000000;
    req0_valid = 1'b1;
    #1;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tb_last = 1'b1;
    res_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid) seen = 1'b1;
      step();
    end
    res_ready = 1'b0;
    check("abandoned", {31'd0, seen}, 32'd0);
    run_op(0, 32'h40c00000, 32'h40000000, 0);

    // Random operations from random requesters with random back-pressure.
    for (int k = 0; k < 10; k++) begin
      id = int'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom;
      run_op(id, a, b, int'($urandom_range(0, 3)));
    end
    contend($urandom, $urandom, $urandom, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
